// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
//
// Purpose:
//   Bundles the two pipeline handshakes around the memory stage. The first
//   is execute -> memory (es_to_ms_valid / es_to_ms_bus / ms_allowin). The
//   second is memory -> writeback (ms_to_ws_valid / ms_to_ws_bus / ws_allowin).
//
// Modports:
//   master : the surrounding pipeline (execute and writeback stages). It
//            drives the incoming instruction and the writeback allowin.
//   slave  : the memory stage itself. It accepts the instruction and
//            presents the result towards writeback.
//
// Signals:
//   es_to_ms_valid  execute holds a valid instruction for the memory stage
//   es_to_ms_bus    {load_type[2:0], gr_we, dest[4:0], alu_result, pc}
//   ms_allowin      memory stage can accept an instruction this cycle
//   ws_allowin      writeback can accept an instruction this cycle
//   ms_to_ws_valid  ms_to_ws_bus carries a valid result
//   ms_to_ws_bus    {gr_we, dest[4:0], final_res[31:0], pc[31:0]}
// ---------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 73,
    parameter int MS_TO_WS_BUS_WD = 70
);
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;

    modport master (
        output es_to_ms_valid,
        output es_to_ms_bus,
        input  ms_allowin,
        output ws_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus
    );

    modport slave (
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        output ms_allowin,
        input  ws_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Purpose:
//   Memory pipeline stage. It accepts one instruction at a time from execute.
//   For loads it waits a variable number of cycles for the data-SRAM
//   response, then aligns and sign/zero-extends the loaded data. It forwards
//   {gr_we, dest, final_res, pc} to writeback. A response that arrives while
//   writeback is stalled is parked in a one-entry buffer, so the SRAM never
//   has to hold its data. The held instruction's destination and value are
//   also published to decode for forwarding and load-use stalls.
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous, active-high reset
//   pipe               mem_stage_if.slave: execute and writeback handshakes
//   data_sram_data_ok  one-cycle pulse: read data for the outstanding load
//   data_sram_rdata    read data, valid while data_sram_data_ok is high
//   ms_fwd_valid       held instruction writes a nonzero GPR
//   ms_fwd_dest        destination register of the held instruction
//   ms_fwd_data        value to forward (final_res)
//   ms_fwd_stall       held load has no data yet; decode must stall
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 73,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  pipe,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_fwd_valid,
    output logic [4:0]  ms_fwd_dest,
    output logic [31:0] ms_fwd_data,
    output logic        ms_fwd_stall
);

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LW   = 3'd5,
        LT_RSV6 = 3'd6,
        LT_RSV7 = 3'd7
    } load_type_e;

    typedef struct packed {
        load_type_e  load_type;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_res;
        logic [31:0] pc;
    } ws_bus_t;

    logic [ES_TO_MS_BUS_WD-1:0] payload_q;
    es_bus_t                    ms;
    ws_bus_t                    ws_bus;

    logic        ms_valid;
    logic        ms_allowin;
    logic        ms_ready_go;
    logic        is_load;
    logic        rdata_buf_valid;
    logic [31:0] rdata_buf;
    logic        buf_capture;
    logic        ws_fire;

    logic [31:0] raw_data;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] aligned_data;
    logic [31:0] final_res;

    assign ms = es_bus_t'(payload_q);

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    // Reserved load codes 6/7 behave as plain ALU ops.
    assign is_load = ms_valid &&
                     (ms.load_type inside {LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LW});

    // A held load is ready either in its data_ok cycle or once parked.
    assign ms_ready_go = !is_load || data_sram_data_ok || rdata_buf_valid;
    assign ms_allowin  = !ms_valid || (ms_ready_go && pipe.ws_allowin);
    assign ws_fire     = ms_valid && ms_ready_go && pipe.ws_allowin;

    assign pipe.ms_allowin     = ms_allowin;
    assign pipe.ms_to_ws_valid = ms_valid && ms_ready_go;

    // ---------------------------------------------------------------------
    // Pipeline register
    // ---------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= pipe.es_to_ms_valid;
        end
    end

    // NOTE: the payload and the parked read data carry no reset. They are
    // only ever consumed under ms_valid / rdata_buf_valid, which are reset.
    always_ff @(posedge clk) begin
        if (pipe.es_to_ms_valid && ms_allowin) begin
            payload_q <= pipe.es_to_ms_bus;
        end
    end

    // ---------------------------------------------------------------------
    // Response buffer: parks read data while writeback is stalled.
    // Capture requires !ws_allowin and clear requires ws_allowin, so the two
    // can never fire in the same cycle. A data_ok with no load held, or with
    // the buffer already full, is dropped here.
    // ---------------------------------------------------------------------
    assign buf_capture = is_load && data_sram_data_ok && !pipe.ws_allowin &&
                         !rdata_buf_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_buf_valid <= 1'b0;
        end else if (ws_fire) begin
            rdata_buf_valid <= 1'b0;
        end else if (buf_capture) begin
            rdata_buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_capture) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    // ---------------------------------------------------------------------
    // Load alignment and extension
    // ---------------------------------------------------------------------
    assign raw_data = rdata_buf_valid ? rdata_buf : data_sram_rdata;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel_byte = raw_data[7:0];
        case (ms.alu_result[1:0])
            2'd1:    sel_byte = raw_data[15:8];
            2'd2:    sel_byte = raw_data[23:16];
            2'd3:    sel_byte = raw_data[31:24];
            default: sel_byte = raw_data[7:0];
        endcase
    end

    // Halfword select ignores alu_result[0].
    assign sel_half = ms.alu_result[1] ? raw_data[31:16] : raw_data[15:0];

    always_comb begin
        aligned_data = raw_data;
        case (ms.load_type)
            LT_LB:   aligned_data = {{24{sel_byte[7]}}, sel_byte};
            LT_LBU:  aligned_data = {24'd0, sel_byte};
            LT_LH:   aligned_data = {{16{sel_half[15]}}, sel_half};
            LT_LHU:  aligned_data = {16'd0, sel_half};
            default: aligned_data = raw_data;
        endcase
    end

    assign final_res = is_load ? aligned_data : ms.alu_result;

    // ---------------------------------------------------------------------
    // Writeback bus. gr_we passes through unmasked; writeback qualifies it
    // with its own valid.
    // ---------------------------------------------------------------------
    assign ws_bus.gr_we     = ms.gr_we;
    assign ws_bus.dest      = ms.dest;
    assign ws_bus.final_res = final_res;
    assign ws_bus.pc        = ms.pc;

    assign pipe.ms_to_ws_bus = MS_TO_WS_BUS_WD'(ws_bus);

    // ---------------------------------------------------------------------
    // Forwarding to decode
    // ---------------------------------------------------------------------
    assign ms_fwd_valid = ms_valid && ms.gr_we && (ms.dest != 5'd0);
    assign ms_fwd_dest  = ms.dest;
    assign ms_fwd_data  = final_res;
    assign ms_fwd_stall = ms_fwd_valid && is_load && !ms_ready_go;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage; producer side of the `ms_to_ws_valid` / `ws_allowin` handshake into the writeback stage.
- Accepts instructions from the execute stage through `es_to_ms_valid` / `ms_allowin`.
- For loads, waits a variable number of cycles for the data-SRAM response, aligns and extends the loaded data, and forwards the final result, destination, write enable and PC to writeback.
- Publishes its in-flight destination and data to decode for forwarding and load-use stalls.

Parameters:
- ES_TO_MS_BUS_WD, 73, width of the execute-to-memory bus: {load_type[2:0], gr_we, dest[4:0], alu_result[31:0], pc[31:0]}.
- MS_TO_WS_BUS_WD, 70, width of the memory-to-writeback bus: {gr_we[69], dest[68:64], final_res[63:32], pc[31:0]}.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- es_to_ms_valid  input  1  execute stage holds a valid instruction for this stage.
- es_to_ms_bus  input  ES_TO_MS_BUS_WD  instruction payload; load_type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6/7 reserved.
- ms_allowin  output  1  this stage can accept an instruction this cycle.
- ws_allowin  input  1  writeback can accept an instruction this cycle.
- ms_to_ws_valid  output  1  the payload on ms_to_ws_bus is valid.
- ms_to_ws_bus  output  MS_TO_WS_BUS_WD  payload to writeback.
- data_sram_data_ok  input  1  single-cycle pulse; read data for the outstanding load is present.
- data_sram_rdata  input  32  read data, valid when data_sram_data_ok=1.
- ms_fwd_valid  output  1  the held instruction writes a nonzero GPR.
- ms_fwd_dest  output  5  destination register of the held instruction.
- ms_fwd_data  output  32  value to forward (final_res).
- ms_fwd_stall  output  1  the held load's data is not yet available; decode must stall.

Behaviour:

Reset (asynchronous, active-high) clears ms_valid and rdata_buf_valid. While in reset:
- ms_to_ws_valid=0, ms_allowin=1.
- ms_fwd_valid=0, ms_fwd_stall=0.
- The payload register is not reset; ms_to_ws_bus is don't-care.
- Reset mid-load discards the instruction and any buffered data. A data_ok pulse in the first cycle after reset is ignored.

Decoding and handshake:
- is_load = ms_valid && load_type in {1..5}. Reserved codes 6/7 are treated as non-load.
- ms_ready_go = !is_load || data_sram_data_ok || rdata_buf_valid.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.

Pipeline register, updated on the clock edge:
- If ms_allowin, ms_valid <= es_to_ms_valid.
- If es_to_ms_valid && ms_allowin, the payload register <= es_to_ms_bus.
- Non-load latency: 1 cycle. A non-load is presented to writeback the cycle after acceptance, combinationally.
- Load timing: data_ok arrives no earlier than the first cycle the load is held here. A load completes in the cycle data_ok arrives if ws_allowin=1.

Response buffer:
- Capture condition: is_load && data_ok && !ws_allowin && !rdata_buf_valid. On capture, rdata_buf <= data_sram_rdata and rdata_buf_valid <= 1.
- Clear rdata_buf_valid when ms_to_ws_valid && ws_allowin.
- A data_ok arriving when no load is held, or when the buffer is already valid, is ignored and must not corrupt state.

Load data selection and alignment:
- Raw data = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- Byte select uses alu_result[1:0]: 0 selects [7:0], 1 selects [15:8], 2 selects [23:16], 3 selects [31:24].
- Halfword select uses alu_result[1] only: 0 selects [15:0], 1 selects [31:16]; alu_result[0] is ignored.
- LW ignores alu_result[1:0].
- LB and LH sign-extend; LBU and LHU zero-extend.

Outputs to writeback:
- final_res = is_load ? aligned data : alu_result.
- ms_to_ws_bus = {gr_we, dest, final_res, pc}.
- gr_we is passed through unmasked; writeback qualifies it with its own valid.

Forwarding outputs:
- ms_fwd_valid = ms_valid && gr_we && (dest != 0).
- ms_fwd_dest = dest.
- ms_fwd_data = final_res.
- ms_fwd_stall = ms_fwd_valid && is_load && !ms_ready_go.

Simultaneous events:
- The held instruction leaving and a new one entering in the same cycle both take effect; the new payload is latched.
- Back-to-back loads are sustained at 1 per cycle when data_ok arrives in each load's first cycle and ws_allowin=1.

Test Plan:
- ALU stream: 3 non-loads (alu_result 0x11, 0x22, 0x33, gr_we=1, dest 5) with ws_allowin=1 -> ms_to_ws_valid for 3 consecutive cycles, each 1 cycle after acceptance; final_res 0x11, 0x22, 0x33; ms_allowin stays 1.
- Load alignment: rdata=0x8899AABB. LB addr 0x1 -> 0xFFFFFFAA. LBU addr 0x3 -> 0x00000088. LH addr 0x2 -> 0xFFFF8899. LHU addr 0x0 -> 0x0000AABB. LW -> 0x8899AABB.
- Variable latency: LW accepted, data_ok arrives 3 cycles later -> ms_to_ws_valid=0, ms_allowin=0 and ms_fwd_stall=1 for 3 cycles; then valid in the data_ok cycle, with ms_fwd_stall=0.
- Downstream backpressure: ws_allowin=0 when data_ok arrives with rdata 0x12345678, held low 2 more cycles -> data buffered; ms_to_ws_valid=1 and final_res=0x12345678 stable throughout; transfer on the cycle ws_allowin rises; buffer cleared.
- Spurious and reset: data_ok pulse while only a non-load is held -> payload unchanged. Reset asserted mid-load -> ms_to_ws_valid=0, ms_allowin=1 immediately (asynchronous); the next LW after reset uses fresh rdata, not stale buffered data.
- Forwarding: instruction with dest=0, gr_we=1 -> ms_fwd_valid=0; dest=7 -> ms_fwd_valid=1, ms_fwd_dest=7.
